// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART control blocks.
package uart_ctrl_pkg;

   localparam int unsigned UART_DATA_W = 8;
   localparam int unsigned MAX_REQ     = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } tx_sched_state_t;

   // Index of the set bit in a one-hot vector of up to MAX_REQ bits.
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last+1, wrapping.
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic          any
);

   always_comb begin
      logic found;
      found = 1'b0;
      gnt   = '0;
      any   = |req;
      for (int unsigned off = 1; off <= N; off++) begin
         int unsigned idx;
         idx = (32'(last) + off) % N;
         if (!found && req[IW'(idx)]) begin
            gnt[IW'(idx)] = 1'b1;
            found         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte streams;
// a grant lasts one message (req_last_i) or MAX_BURST bytes.
module uart_tx_sched
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned MAX_BURST   = 16,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic                           sys_clk_i,
   input  logic                           sys_rst_ni,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [UART_DATA_W*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]             req_last_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic [NUM_REQ-1:0]             grant_o,
   output logic                           uart_wr_o,
   output logic [UART_DATA_W-1:0]         uart_dat_o,
   input  logic                           uart_busy_i,
   output logic                           err_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = 8;

   tx_sched_state_t        state_q, state_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [CNT_W-1:0]       burst_q, burst_d;
   logic [CNT_W-1:0]       tmo_q, tmo_d;
   logic [UART_DATA_W-1:0] dat_q, dat_d;
   logic                   wr_q, wr_d;
   logic                   err_q, err_d;
   logic                   msg_last_q, msg_last_d;

   logic [NUM_REQ-1:0]     arb_gnt;
   logic                   arb_any;
   logic [IDX_W-1:0]       gnt_idx;
   logic                   owner_valid;
   logic                   owner_last;
   logic [UART_DATA_W-1:0] owner_byte;
   logic                   ready_c;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req  (req_valid_i),
      .last (last_q),
      .gnt  (arb_gnt),
      .any  (arb_any)
   );

   assign gnt_idx = IDX_W'(onehot_to_idx(MAX_REQ'(grant_q)));

   // Select the current owner's valid, last and byte.
   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_byte  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            owner_valid = req_valid_i[i];
            owner_last  = req_last_i[i];
            owner_byte  = req_data_i[i*UART_DATA_W +: UART_DATA_W];
         end
      end
   end

   assign ready_c     = (state_q == ISSUE) && !uart_busy_i;
   assign req_ready_o = ready_c ? grant_q : '0;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      burst_d    = burst_q;
      tmo_d      = tmo_q;
      dat_d      = dat_q;
      wr_d       = 1'b0;
      err_d      = 1'b0;
      msg_last_d = msg_last_q;
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               grant_d = arb_gnt;
               burst_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (ready_c && owner_valid) begin
               dat_d      = owner_byte;
               wr_d       = 1'b1;
               burst_d    = burst_q + CNT_W'(1);
               msg_last_d = owner_last;
               tmo_d      = '0;
               state_d    = WAIT_ACK;
            end else if (!owner_valid) begin
               grant_d = '0;
               last_d  = gnt_idx;
               state_d = IDLE;
            end
         end
         // Only a high busy acknowledges; it wins over a coincident timeout.
         WAIT_ACK: begin
            if (uart_busy_i) begin
               state_d = WAIT_DONE;
            end else if (tmo_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               grant_d = '0;
               last_d  = gnt_idx;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!uart_busy_i) begin
               if (msg_last_q || (burst_q == CNT_W'(MAX_BURST))) begin
                  grant_d = '0;
                  last_d  = gnt_idx;
                  state_d = IDLE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (!sys_rst_ni) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         last_q     <= IDX_W'(NUM_REQ - 1);
         burst_q    <= '0;
         tmo_q      <= '0;
         dat_q      <= '0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         msg_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         burst_q    <= burst_d;
         tmo_q      <= tmo_d;
         dat_q      <= dat_d;
         wr_q       <= wr_d;
         err_q      <= err_d;
         msg_last_q <= msg_last_d;
      end
   end

   assign grant_o    = grant_q;
   assign uart_wr_o  = wr_q;
   assign uart_dat_o = dat_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus a randomized run against a
// transaction-level round-robin model.
module tb_uart_tx_sched;

   localparam int unsigned NR = 4;
   localparam int unsigned MB = 4;
   localparam int unsigned AT = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid, req_last, req_ready, grant;
   logic [8*NR-1:0]   req_data;
   logic              wr, busy, err;
   logic [7:0]        dat;

   logic [8:0]        rq[NR][$];
   logic [8:0]        exq[NR][$];
   bit                en[NR];
   logic [NR-1:0]     fire;
   bit                uart_auto, busy_rand, start_pending;
   int                busy_len, busy_left;
   int                n_pass, n_total;

   always #5 clk = ~clk;

   uart_tx_sched #(.NUM_REQ(NR), .MAX_BURST(MB), .ACK_TIMEOUT(AT)) dut (
      .sys_clk_i   (clk),
      .sys_rst_ni  (rst_n),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .grant_o     (grant),
      .uart_wr_o   (wr),
      .uart_dat_o  (dat),
      .uart_busy_i (busy),
      .err_o       (err)
   );

   function automatic int oh_idx(input logic [NR-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < int'(NR); i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic drive();
      for (int k = 0; k < int'(NR); k++) begin
         req_valid[k] = en[k] && (rq[k].size() > 0);
         if (rq[k].size() > 0) begin
            req_data[8*k +: 8] = rq[k][0][7:0];
            req_last[k]        = rq[k][0][8];
         end else begin
            req_data[8*k +: 8] = 8'h00;
            req_last[k]        = 1'b0;
         end
      end
   endtask

   // One clock: capture handshakes before the edge, update requesters and UART model after it.
   task automatic tick();
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < int'(NR); k++) if (fire[k]) rq[k].delete(0);
      drive();
      if (uart_auto) begin
         if (busy_left > 0) busy_left--;
         if (start_pending) begin
            busy_left     = busy_rand ? int'($urandom_range(6, 1)) : busy_len;
            start_pending = 1'b0;
         end
         if (wr) start_pending = 1'b1;
         busy = (busy_left > 0);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; uart_auto = 1'b1; busy = 1'b0; busy_left = 0; start_pending = 1'b0;
      for (int k = 0; k < int'(NR); k++) begin
         rq[k].delete(); exq[k].delete(); en[k] = 1'b1;
      end
      drive(); tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rq[0].push_back({1'b1, 8'h5A});
      drive(); tick(); tick();
      n_total++; if (grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", grant); else n_pass++;
      n_total++; if (wr !== 1'b0) $display("FAIL reset_wr got=%b exp=0", wr); else n_pass++;
      n_total++; if (dat !== 8'h00) $display("FAIL reset_dat got=%h exp=00", dat); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", req_ready); else n_pass++;
      rq[0].delete(); drive();
      rst_n = 1'b1;
   endtask

   task automatic test_single_byte();
      int nwr, wr_at, chk_cyc;
      logic [7:0] got;
      logic pb;
      busy_len = 11; busy_rand = 1'b0; uart_auto = 1'b1;
      nwr = 0; wr_at = -1; chk_cyc = -1; got = 8'h00;
      rq[0].push_back({1'b1, 8'hA5});
      drive();
      tick();
      n_total++; if (grant !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", grant); else n_pass++;
      for (int t = 2; t < 40; t++) begin
         pb = busy;
         tick();
         if (wr) begin nwr++; got = dat; if (wr_at < 0) wr_at = t; end
         if (pb && !busy && chk_cyc < 0) chk_cyc = t + 1;
         if (t == chk_cyc) begin
            n_total++; if (grant !== 4'b0000) $display("FAIL single_release got=%b exp=0000", grant); else n_pass++;
         end
      end
      n_total++; if (nwr !== 1) $display("FAIL single_wr_count got=%0d exp=1", nwr); else n_pass++;
      n_total++; if (got !== 8'hA5) $display("FAIL single_dat got=%h exp=a5", got); else n_pass++;
      n_total++; if (wr_at !== 2) $display("FAIL single_latency got=%0d exp=2", wr_at); else n_pass++;
      n_total++; if (chk_cyc < 0) $display("FAIL single_busy_fall got=%0d exp=>0", chk_cyc); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g[4];
      logic [7:0] exp_b[4];
      logic [3:0] prev_g;
      int ng, nb;
      bit r2;
      do_reset();
      busy_rand = 1'b1;
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
      exp_b[0] = 8'h10;   exp_b[1] = 8'h21;   exp_b[2] = 8'h33;   exp_b[3] = 8'h14;
      rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h14});
      rq[1].push_back({1'b1, 8'h21}); rq[3].push_back({1'b1, 8'h33});
      drive();
      ng = 0; nb = 0; r2 = 1'b0; prev_g = grant;
      for (int t = 0; t < 200; t++) begin
         tick();
         if (req_ready[2]) r2 = 1'b1;
         if (prev_g == 4'b0000 && grant != 4'b0000) begin
            if (ng < 4) begin
               n_total++; if (grant !== exp_g[ng]) $display("FAIL rr_grant%0d got=%b exp=%b", ng, grant, exp_g[ng]); else n_pass++;
            end
            ng++;
         end
         if (wr) begin
            if (nb < 4) begin
               n_total++; if (dat !== exp_b[nb]) $display("FAIL rr_byte%0d got=%h exp=%h", nb, dat, exp_b[nb]); else n_pass++;
            end
            nb++;
         end
         prev_g = grant;
      end
      n_total++; if (ng !== 4) $display("FAIL rr_grant_count got=%0d exp=4", ng); else n_pass++;
      n_total++; if (nb !== 4) $display("FAIL rr_byte_count got=%0d exp=4", nb); else n_pass++;
      n_total++; if (r2 !== 1'b0) $display("FAIL rr_ready2 got=%b exp=0", r2); else n_pass++;
   endtask

   task automatic test_burst_cap();
      int eo[12];
      logic [7:0] eb[12];
      logic [3:0] exp_g[3];
      logic [3:0] prev_g;
      int nw, ng;
      do_reset();
      busy_rand = 1'b1;
      for (int i = 0; i < 10; i++) rq[2].push_back({1'b0, 8'(8'h20 + i)});
      for (int i = 0; i < 4; i++) begin eo[i] = 2; eb[i] = 8'(8'h20 + i); end
      eo[4] = 1; eb[4] = 8'h40; eo[5] = 1; eb[5] = 8'h41;
      for (int i = 4; i < 10; i++) begin eo[i+2] = 2; eb[i+2] = 8'(8'h20 + i); end
      exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b0100;
      drive();
      tick();
      n_total++; if (grant !== 4'b0100) $display("FAIL burst_first_grant got=%b exp=0100", grant); else n_pass++;
      rq[1].push_back({1'b0, 8'h40}); rq[1].push_back({1'b1, 8'h41});
      nw = 0; ng = 0; prev_g = grant;
      for (int t = 0; t < 400; t++) begin
         tick();
         if (wr) begin
            if (nw < 12) begin
               n_total++;
               if (oh_idx(grant) !== eo[nw] || dat !== eb[nw])
                  $display("FAIL burst_wr%0d got=req%0d/%h exp=req%0d/%h", nw, oh_idx(grant), dat, eo[nw], eb[nw]);
               else n_pass++;
            end
            nw++;
         end
         if (prev_g == 4'b0000 && grant != 4'b0000) begin
            if (ng < 3) begin
               n_total++; if (grant !== exp_g[ng]) $display("FAIL burst_grant%0d got=%b exp=%b", ng, grant, exp_g[ng]); else n_pass++;
            end
            ng++;
         end
         prev_g = grant;
      end
      n_total++; if (nw !== 12) $display("FAIL burst_wr_count got=%0d exp=12", nw); else n_pass++;
      n_total++; if (ng !== 3) $display("FAIL burst_grant_count got=%0d exp=3", ng); else n_pass++;
   endtask

   task automatic test_timeout();
      int tw, te, nerr;
      logic [3:0] next_g, prev_g;
      do_reset();
      uart_auto = 1'b0; busy = 1'b0; busy_rand = 1'b1;
      rq[1].push_back({1'b1, 8'h51}); rq[2].push_back({1'b1, 8'h62});
      drive();
      tw = -1; te = -1; nerr = 0; next_g = 4'b0000; prev_g = grant;
      for (int t = 1; t < 150; t++) begin
         tick();
         if (wr && tw < 0) tw = t;
         if (err) begin
            nerr++;
            if (te < 0) begin
               te = t;
               n_total++; if (grant !== 4'b0000) $display("FAIL timeout_grant got=%b exp=0000", grant); else n_pass++;
               uart_auto = 1'b1;
            end
         end
         if (te >= 0 && prev_g == 4'b0000 && grant != 4'b0000 && next_g == 4'b0000) next_g = grant;
         prev_g = grant;
      end
      n_total++; if (te - tw !== int'(AT)) $display("FAIL timeout_delay got=%0d exp=%0d", te - tw, AT); else n_pass++;
      n_total++; if (nerr !== 1) $display("FAIL timeout_err_count got=%0d exp=1", nerr); else n_pass++;
      n_total++; if (next_g !== 4'b0100) $display("FAIL timeout_next got=%b exp=0100", next_g); else n_pass++;
   endtask

   task automatic test_owner_stall();
      int nwr, fell, nwr2;
      logic pb;
      do_reset();
      busy_rand = 1'b0; busy_len = 5;
      rq[0].push_back({1'b0, 8'h71}); rq[0].push_back({1'b0, 8'h72}); rq[0].push_back({1'b1, 8'h73});
      drive();
      nwr = 0; fell = -1;
      for (int t = 1; t < 60; t++) begin
         pb = busy;
         tick();
         if (wr) begin nwr++; if (nwr == 1) en[0] = 1'b0; end
         if (pb && !busy && fell < 0) fell = t;
         if (fell >= 0 && t == fell + 2) begin
            n_total++; if (grant !== 4'b0000) $display("FAIL stall_release got=%b exp=0000", grant); else n_pass++;
         end
      end
      n_total++; if (nwr !== 1) $display("FAIL stall_wr_count got=%0d exp=1", nwr); else n_pass++;
      en[0] = 1'b1; drive();
      nwr2 = 0;
      for (int t = 0; t < 80; t++) begin tick(); if (wr) nwr2++; end
      n_total++; if (nwr2 !== 2) $display("FAIL stall_resume got=%0d exp=2", nwr2); else n_pass++;
   endtask

   task automatic test_reset_wait_done();
      int nb, nwr;
      logic [7:0] got;
      do_reset();
      busy_rand = 1'b0; busy_len = 10;
      rq[3].push_back({1'b0, 8'h81}); rq[3].push_back({1'b1, 8'h82});
      drive();
      nb = 0;
      for (int t = 0; t < 40 && nb < 3; t++) begin tick(); if (busy) nb++; end
      n_total++; if (nb !== 3) $display("FAIL rstwd_reach got=%0d exp=3", nb); else n_pass++;
      rst_n = 1'b0; uart_auto = 1'b0; busy = 1'b0; busy_left = 0; start_pending = 1'b0;
      rq[3].delete();
      tick();
      n_total++; if (grant !== 4'b0000) $display("FAIL rstwd_grant got=%b exp=0000", grant); else n_pass++;
      n_total++; if (wr !== 1'b0) $display("FAIL rstwd_wr got=%b exp=0", wr); else n_pass++;
      n_total++; if (dat !== 8'h00) $display("FAIL rstwd_dat got=%h exp=00", dat); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL rstwd_err got=%b exp=0", err); else n_pass++;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL rstwd_ready got=%b exp=0000", req_ready); else n_pass++;
      rst_n = 1'b1; uart_auto = 1'b1;
      nwr = 0;
      for (int t = 0; t < 20; t++) begin tick(); if (wr) nwr++; end
      n_total++; if (nwr !== 0) $display("FAIL rstwd_quiet got=%0d exp=0", nwr); else n_pass++;
      // Reset on the accepting edge must cancel the pending strobe.
      rq[0].push_back({1'b1, 8'h99}); drive();
      tick();
      rst_n = 1'b0;
      tick();
      n_total++; if (wr !== 1'b0) $display("FAIL rst_cancel_wr got=%b exp=0", wr); else n_pass++;
      rq[0].delete(); drive(); rst_n = 1'b1;
      rq[0].push_back({1'b1, 8'h90}); drive();
      nwr = 0; got = 8'h00;
      for (int t = 0; t < 20; t++) begin tick(); if (wr) begin nwr++; got = dat; end end
      n_total++; if (nwr !== 1 || got !== 8'h90) $display("FAIL rstwd_new got=%0d/%h exp=1/90", nwr, got); else n_pass++;
   endtask

   task automatic test_random();
      int mlast, owner, sent, len, k, remaining;
      bit lastf, endlast, ok;
      logic [NR-1:0] vprev, prev_g, expg;
      logic pb, pw;
      logic [8:0] e, b;
      do_reset();
      busy_rand = 1'b1;
      mlast = int'(NR) - 1; owner = -1; sent = 0; lastf = 1'b0;
      for (int t = 0; t < 1500; t++) begin
         vprev = req_valid; pb = busy; pw = wr; prev_g = grant;
         tick();
         if (prev_g == '0 && grant != '0) begin
            expg = '0;
            for (int off = 1; off <= int'(NR); off++) begin
               k = (mlast + off) % int'(NR);
               if (vprev[k] && expg == '0) expg[k] = 1'b1;
            end
            n_total++; if (grant !== expg) $display("FAIL rand_grant t=%0d got=%b exp=%b", t, grant, expg); else n_pass++;
            owner = oh_idx(grant); sent = 0; lastf = 1'b0;
         end
         if (wr) begin
            n_total++; if (pw !== 1'b0) $display("FAIL rand_wr_gap t=%0d got=%b exp=0", t, pw); else n_pass++;
            n_total++; if (pb !== 1'b0) $display("FAIL rand_wr_busy t=%0d got=%b exp=0", t, pb); else n_pass++;
            n_total++;
            if (owner < 0 || exq[owner].size() == 0) begin
               $display("FAIL rand_unexpected_wr t=%0d got=%h exp=none", t, dat);
            end else begin
               e = exq[owner].pop_front();
               lastf = e[8];
               if (dat !== e[7:0]) $display("FAIL rand_byte t=%0d got=%h exp=%h", t, dat, e[7:0]); else n_pass++;
            end
            sent++;
            n_total++; if (sent > int'(MB)) $display("FAIL rand_burst t=%0d got=%0d exp=<=%0d", t, sent, MB); else n_pass++;
         end
         if (prev_g != '0 && grant == '0 && owner >= 0) begin
            ok = lastf || (sent == int'(MB)) || (exq[owner].size() == 0);
            n_total++; if (ok !== 1'b1) $display("FAIL rand_release t=%0d got=sent%0d exp=justified", t, sent); else n_pass++;
            mlast = owner; owner = -1;
         end
         if (t < 1200) begin
            for (int r = 0; r < int'(NR); r++) begin
               if (rq[r].size() == 0 && !grant[r] && $urandom_range(7, 0) == 0) begin
                  len = int'($urandom_range(7, 1));
                  endlast = ($urandom_range(3, 0) != 0);
                  for (int i = 0; i < len; i++) begin
                     b = {1'((i == len - 1) && endlast), 8'($urandom)};
                     rq[r].push_back(b); exq[r].push_back(b);
                  end
               end
            end
         end else begin
            remaining = 0;
            for (int r = 0; r < int'(NR); r++) remaining += exq[r].size();
            if (remaining == 0 && grant == '0) break;
         end
      end
      remaining = 0;
      for (int r = 0; r < int'(NR); r++) remaining += exq[r].size();
      n_total++; if (remaining !== 0) $display("FAIL rand_drain got=%0d exp=0", remaining); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; busy = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
      uart_auto = 1'b1; busy_rand = 1'b0; busy_len = 4; busy_left = 0; start_pending = 1'b0;
      fire = '0; n_pass = 0; n_total = 0;
      for (int k = 0; k < int'(NR); k++) en[k] = 1'b1;
      test_reset();
      test_single_byte();
      test_round_robin();
      test_burst_cap();
      test_timeout();
      test_owner_stall();
      test_reset_wait_done();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
